// File: rtl/move_fetch_seq.sv
// Move-instruction fetch sequencer: gathers src dev/addr and tgt dev/addr words
// from the IR stream, range-checks device IDs and presents one transfer command.
module move_fetch_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_DEVICES = 8,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_ir_valid,
  input  logic [DATA_WIDTH-1:0] i_ir,
  output logic                  o_ir_ready,
  output logic                  o_target_device_flag,
  output logic                  o_cmd_valid,
  input  logic                  i_cmd_ready,
  output logic [DATA_WIDTH-1:0] o_src_device,
  output logic [DATA_WIDTH-1:0] o_src_address,
  output logic [DATA_WIDTH-1:0] o_tgt_device,
  output logic [DATA_WIDTH-1:0] o_tgt_address,
  output logic                  o_cmd_err,
  output logic [CNT_WIDTH-1:0]  o_inst_count
);

  typedef enum logic [2:0] {
    S_SRC_DEV  = 3'd0,
    S_SRC_ADDR = 3'd1,
    S_TGT_DEV  = 3'd2,
    S_TGT_ADDR = 3'd3,
    S_ISSUE    = 3'd4
  } state_t;

  // One extra bit so NUM_DEVICES == 2**DATA_WIDTH is representable.
  localparam logic [DATA_WIDTH:0] DEV_LIMIT = (DATA_WIDTH+1)'(NUM_DEVICES);

  state_t state;
  logic   accept;
  logic   src_err;
  logic   tgt_err;

  assign o_ir_ready = (state == S_SRC_DEV) || (state == S_SRC_ADDR) ||
                      (state == S_TGT_DEV) || (state == S_TGT_ADDR);
  assign o_target_device_flag = (state == S_TGT_DEV);
  assign accept  = i_ir_valid & o_ir_ready;
  assign src_err = {1'b0, o_src_device} >= DEV_LIMIT;
  assign tgt_err = {1'b0, o_tgt_device} >= DEV_LIMIT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_SRC_DEV;
      o_cmd_valid   <= 1'b0;
      o_src_device  <= '0;
      o_src_address <= '0;
      o_tgt_device  <= '0;
      o_tgt_address <= '0;
      o_cmd_err     <= 1'b0;
      o_inst_count  <= '0;
    end else if (state == S_ISSUE) begin
      // A completed handshake wins over flush so the command is still counted.
      if (i_cmd_ready) begin
        o_inst_count <= o_inst_count + CNT_WIDTH'(1);
        state        <= S_SRC_DEV;
        o_cmd_valid  <= 1'b0;
      end else if (i_flush) begin
        state       <= S_SRC_DEV;
        o_cmd_valid <= 1'b0;
      end
    end else if (i_flush) begin
      state       <= S_SRC_DEV;
      o_cmd_valid <= 1'b0;
    end else begin
      case (state)
        S_SRC_DEV: if (accept) begin
          o_src_device <= i_ir;
          state        <= S_SRC_ADDR;
        end
        S_SRC_ADDR: if (accept) begin
          o_src_address <= i_ir;
          state         <= S_TGT_DEV;
        end
        S_TGT_DEV: if (accept) begin
          o_tgt_device <= i_ir;
          state        <= S_TGT_ADDR;
        end
        S_TGT_ADDR: if (accept) begin
          o_tgt_address <= i_ir;
          o_cmd_err     <= src_err | tgt_err;
          o_cmd_valid   <= 1'b1;
          state         <= S_ISSUE;
        end
        default: begin
          state       <= S_SRC_DEV;
          o_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_fetch_seq.sv
// Bench for move_fetch_seq: directed scenarios plus random traffic, each cycle
// compared against a word-collecting reference model.
module tb_move_fetch_seq;

  localparam int DW = 16;
  localparam int ND = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_flush;
  logic          i_ir_valid;
  logic [DW-1:0] i_ir;
  logic          o_ir_ready;
  logic          o_target_device_flag;
  logic          o_cmd_valid;
  logic          i_cmd_ready;
  logic [DW-1:0] o_src_device;
  logic [DW-1:0] o_src_address;
  logic [DW-1:0] o_tgt_device;
  logic [DW-1:0] o_tgt_address;
  logic          o_cmd_err;
  logic [CW-1:0] o_inst_count;

  move_fetch_seq #(.DATA_WIDTH(DW), .NUM_DEVICES(ND), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_ir_valid(i_ir_valid),
    .i_ir(i_ir), .o_ir_ready(o_ir_ready),
    .o_target_device_flag(o_target_device_flag), .o_cmd_valid(o_cmd_valid),
    .i_cmd_ready(i_cmd_ready), .o_src_device(o_src_device),
    .o_src_address(o_src_address), .o_tgt_device(o_tgt_device),
    .o_tgt_address(o_tgt_address), .o_cmd_err(o_cmd_err),
    .o_inst_count(o_inst_count)
  );

  always #5 clk = ~clk;

  int unsigned tests  = 0;
  int unsigned errors = 0;

  // Reference model: number of words gathered so far (4 = command pending),
  // the four captured fields, the error flag and the issued count.
  int unsigned   m_words;
  logic [DW-1:0] m_fld [4];
  logic          m_err;
  int unsigned   m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_words = 0;
    m_err   = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < 4; i++) m_fld[i] = '0;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else if (m_words == 4) begin
      if (i_cmd_ready) begin
        m_cnt   = (m_cnt + 1) % (1 << CW);
        m_words = 0;
      end else if (i_flush) begin
        m_words = 0;
      end
    end else if (i_flush) begin
      m_words = 0;
    end else if (i_ir_valid) begin
      m_fld[m_words] = i_ir;
      if (m_words == 3)
        m_err = (int'(m_fld[0]) >= ND) || (int'(m_fld[2]) >= ND);
      m_words++;
    end
  endtask

  task automatic check_model();
    chk("ir_ready",    32'(o_ir_ready),           32'(m_words < 4));
    chk("tgt_flag",    32'(o_target_device_flag), 32'(m_words == 2));
    chk("cmd_valid",   32'(o_cmd_valid),          32'(m_words == 4));
    chk("src_device",  32'(o_src_device),         32'(m_fld[0]));
    chk("src_address", 32'(o_src_address),        32'(m_fld[1]));
    chk("tgt_device",  32'(o_tgt_device),         32'(m_fld[2]));
    chk("tgt_address", 32'(o_tgt_address),        32'(m_fld[3]));
    chk("cmd_err",     32'(o_cmd_err),            32'(m_err));
    chk("inst_count",  32'(o_inst_count),         m_cnt);
  endtask

  // Apply inputs for one cycle, check outputs mid-cycle, then advance the model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic cr,
                      input logic fl, input logic rn);
    i_ir_valid  = v;
    i_ir        = d;
    i_cmd_ready = cr;
    i_flush     = fl;
    rst_n       = rn;
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic feed4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] d);
    step(1'b1, a, 1'b0, 1'b0, 1'b1);
    step(1'b1, b, 1'b0, 1'b0, 1'b1);
    step(1'b1, c, 1'b0, 1'b0, 1'b1);
    step(1'b1, d, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic issue();
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; i_flush = 1'b0; i_ir_valid = 1'b0; i_ir = '0; i_cmd_ready = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("reset_valid", 32'(o_cmd_valid), 0);
    chk("reset_count", 32'(o_inst_count), 0);

    // Back-to-back instruction with the command accepted immediately.
    step(1'b1, 16'h3,  1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h10, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h5,  1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h20, 1'b1, 1'b0, 1'b1);
    chk("t1_valid", 32'(o_cmd_valid), 1);
    chk("t1_src",   32'(o_src_device), 32'h3);
    chk("t1_saddr", 32'(o_src_address), 32'h10);
    chk("t1_tgt",   32'(o_tgt_device), 32'h5);
    chk("t1_taddr", 32'(o_tgt_address), 32'h20);
    chk("t1_err",   32'(o_cmd_err), 0);
    issue();
    chk("t1_count", 32'(o_inst_count), 1);

    // Stalled word stream and stalled command acceptance.
    foreach (m_fld[k]) begin
      step(1'b1, 16'(k + 1), 1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b0, 16'hdead, 1'b0, 1'b0, 1'b1);
    end
    repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t2_held_valid", 32'(o_cmd_valid), 1);
    chk("t2_held_ready", 32'(o_ir_ready), 0);
    issue();

    // Device range checks.
    feed4(16'd7, 16'h1, 16'd8, 16'h2);
    chk("t3_tgt8", 32'(o_cmd_err), 1);
    issue();
    feed4(16'd8, 16'h1, 16'd0, 16'h2);
    chk("t3_src8", 32'(o_cmd_err), 1);
    issue();
    feed4(16'd7, 16'h1, 16'd0, 16'h2);
    chk("t3_ok", 32'(o_cmd_err), 0);
    issue();

    // Flush mid-instruction, with a word offered on the flush cycle.
    step(1'b1, 16'h9, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h9, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h9, 1'b0, 1'b1, 1'b1);
    feed4(16'h1, 16'h2, 16'h3, 16'h4);
    chk("t4_src",   32'(o_src_device), 1);
    chk("t4_taddr", 32'(o_tgt_address), 4);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("t4_drop_valid", 32'(o_cmd_valid), 0);
    chk("t4_drop_count", 32'(o_inst_count), m_cnt);
    // Flush together with a handshake: counted.
    feed4(16'h1, 16'h2, 16'h3, 16'h4);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Counter wrap across five commands.
    for (int n = 0; n < 5; n++) begin
      feed4(16'h1, 16'h2, 16'h3, 16'h4);
      issue();
      chk("t5_wrap", 32'(o_inst_count), m_cnt);
    end

    // Reset after three words, then a clean instruction.
    step(1'b1, 16'h2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h3, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h4, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h5, 1'b1, 1'b1, 1'b0);
    chk("t6_flag",  32'(o_target_device_flag), 0);
    chk("t6_src",   32'(o_src_device), 0);
    chk("t6_count", 32'(o_inst_count), 0);
    feed4(16'h6, 16'h7, 16'h1, 16'h8);
    chk("t6_decode", 32'(o_tgt_address), 8);
    issue();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 11)) : DW'($urandom);
      step(($urandom_range(0, 9) < 7), d, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 99) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
